// File: rtl/bcd_timer_ctrl.sv
// Programmable BCD up-timer controller: command FSM, count-tick prescaler,
// cascaded decade digits with carry and a one-cycle done pulse at target.
module bcd_timer_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [4*DIGITS-1:0]   cmd_target,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  running,
    output logic                  done,
    output logic [1:0]            state
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    count_q, count_d;
    logic [W-1:0]    target_q, target_d;
    logic [PW-1:0]   presc_q, presc_d;

    logic            accept;
    logic            tick;
    logic            match;
    logic [W-1:0]    inc_bcd;

    // Handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both high; cmd_ready depends only on state, never on cmd_valid.
    assign accept = cmd_valid && cmd_ready;
    assign tick   = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

    // Decade increment: each digit at 9 rolls to 0 and passes the carry upward.
    always_comb begin
        logic carry;
        carry   = 1'b1;
        inc_bcd = count_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    inc_bcd[4*i +: 4] = 4'd0;
                end else begin
                    inc_bcd[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    // A zero target means free-run, so it never matches.
    assign match = tick && (target_q != '0) && (inc_bcd == target_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            target_q <= '0;
            presc_q  <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            target_q <= target_d;
            presc_q  <= presc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        target_d = target_q;
        presc_d  = presc_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_START: begin
                            state_d = ST_RUN;
                            presc_d = '0;
                        end
                        OP_CLEAR: begin
                            count_d = '0;
                            presc_d = '0;
                        end
                        OP_LOAD:  target_d = cmd_target;
                        default:  ;
                    endcase
                end
            end
            ST_RUN: begin
                if (accept && (cmd_op == OP_CLEAR)) begin
                    count_d = '0;
                    presc_d = '0;
                end else begin
                    if (tick) begin
                        count_d = inc_bcd;
                        presc_d = '0;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                    // The compare above used the old target; a new one applies next cycle.
                    if (accept && (cmd_op == OP_LOAD)) begin
                        target_d = cmd_target;
                    end
                    if (match) begin
                        state_d = ST_DONE;
                    end else if (accept && (cmd_op == OP_STOP)) begin
                        state_d = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_START: state_d = ST_RUN;
                        OP_CLEAR: begin
                            count_d = '0;
                            presc_d = '0;
                            state_d = ST_IDLE;
                        end
                        OP_LOAD:  target_d = cmd_target;
                        default:  ;
                    endcase
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q != ST_DONE);
        running   = (state_q == ST_RUN);
        done      = (state_q == ST_DONE);
        state     = state_q;
        count_bcd = count_q;
    end

endmodule
